// File: rtl/ppu_pkg.sv
// Shared PPU definitions: VRAM bus width and the VRAM arbiter state encoding.
package ppu_pkg;

  localparam int PPU_VRAM_AW = 14;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_D,
    CPU_A,
    CPU_D
  } vram_arb_state_t;

endpackage

// File: rtl/ppu_vram_arbiter_if.sv
// External VRAM/CHR bus of the PPU. The arbiter is the master: it drives the
// strobes, address and write data and receives read data from memory.
interface ppu_vram_arbiter_if
  import ppu_pkg::*;
#(
  parameter int AW = PPU_VRAM_AW
);

  logic          vram_r;
  logic          vram_w;
  logic [AW-1:0] vram_a;
  logic [7:0]    vram_dout;
  logic [7:0]    vram_din;

  modport master (
    output vram_r,
    output vram_w,
    output vram_a,
    output vram_dout,
    input  vram_din
  );

  modport slave (
    input  vram_r,
    input  vram_w,
    input  vram_a,
    input  vram_dout,
    output vram_din
  );

endinterface

// File: rtl/ppu_vram_arbiter.sv
// Shares the PPU's single VRAM bus between the render fetch engine and the
// CPU-side PPUDATA port. Every access is a two-tick transaction (address
// phase, data phase); the next owner is chosen at the end of each data phase
// or while idle, so back-to-back transactions run without a bubble.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int AW = PPU_VRAM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          render_active,
  // render fetch port
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [7:0]    fetch_rdata,
  // CPU register port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic [7:0]    cpu_rdata,
  // VRAM bus
  ppu_vram_arbiter_if.master vram
);

  vram_arb_state_t state_q;

  logic          fetch_gnt_q;
  logic          fetch_valid_q;
  logic [7:0]    fetch_rdata_q;
  logic          cpu_busy_q;
  logic          cpu_done_q;
  logic [7:0]    cpu_rdata_q;

  // single-entry CPU slot
  logic          slot_we_q;
  logic [AW-1:0] slot_addr_q;
  logic [7:0]    slot_wdata_q;

  logic          vram_r_q;
  logic          vram_w_q;
  logic [AW-1:0] vram_a_q;
  logic [7:0]    vram_dout_q;

  logic          slot_load;
  logic          cpu_ready;
  logic          pick_fetch;
  logic          pick_cpu;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_wdata;

  // Decision inputs: a CPU access is ready if the slot holds an unserved
  // request or one is being loaded this tick; a loading request is forwarded
  // straight from the port because the slot registers are not written yet.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    slot_load  = 1'b0;
    cpu_ready  = 1'b0;
    pick_fetch = 1'b0;
    pick_cpu   = 1'b0;
    sel_we     = slot_we_q;
    sel_addr   = slot_addr_q;
    sel_wdata  = slot_wdata_q;

    slot_load = cpu_req && !cpu_busy_q;
    cpu_ready = slot_load ||
                (cpu_busy_q && (state_q != CPU_A) && (state_q != CPU_D));

    if (slot_load) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end

    // Rendering gives fetches priority; outside rendering the CPU goes first.
    pick_fetch = fetch_req && (render_active || !cpu_ready);
    pick_cpu   = !pick_fetch && cpu_ready;
  end

  // Arbiter FSM with registered bus strobes, handshake pulses and CPU slot.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (reset) begin
      state_q       <= IDLE;
      fetch_gnt_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_rdata_q <= '0;
      cpu_busy_q    <= 1'b0;
      cpu_done_q    <= 1'b0;
      cpu_rdata_q   <= '0;
      slot_we_q     <= 1'b0;
      slot_addr_q   <= '0;
      slot_wdata_q  <= '0;
      vram_r_q      <= 1'b0;
      vram_w_q      <= 1'b0;
      vram_a_q      <= '0;
      vram_dout_q   <= '0;
    end else if (ce) begin
      fetch_gnt_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      cpu_done_q    <= 1'b0;

      if (slot_load) begin
        cpu_busy_q   <= 1'b1;
        slot_we_q    <= cpu_we;
        slot_addr_q  <= cpu_addr;
        slot_wdata_q <= cpu_wdata;
      end

      // completion side effects of the data phase being left
      if (state_q == FETCH_D) begin
        fetch_rdata_q <= vram.vram_din;
        fetch_valid_q <= 1'b1;
      end
      if (state_q == CPU_D) begin
        if (!slot_we_q) cpu_rdata_q <= vram.vram_din;
        cpu_done_q <= 1'b1;
        cpu_busy_q <= 1'b0;
      end

      case (state_q)
        FETCH_A: state_q <= FETCH_D;
        CPU_A:   state_q <= CPU_D;
        default: begin
          // decision point: IDLE, FETCH_D or CPU_D
          if (pick_fetch) begin
            state_q     <= FETCH_A;
            fetch_gnt_q <= 1'b1;
            vram_a_q    <= fetch_addr;
            vram_r_q    <= 1'b1;
            vram_w_q    <= 1'b0;
          end else if (pick_cpu) begin
            state_q     <= CPU_A;
            vram_a_q    <= sel_addr;
            vram_r_q    <= !sel_we;
            vram_w_q    <= sel_we;
            vram_dout_q <= sel_wdata;
          end else begin
            state_q  <= IDLE;
            vram_r_q <= 1'b0;
            vram_w_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign fetch_gnt      = fetch_gnt_q;
  assign fetch_valid    = fetch_valid_q;
  assign fetch_rdata    = fetch_rdata_q;
  assign cpu_busy       = cpu_busy_q;
  assign cpu_done       = cpu_done_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign vram.vram_r    = vram_r_q;
  assign vram.vram_w    = vram_w_q;
  assign vram.vram_a    = vram_a_q;
  assign vram.vram_dout = vram_dout_q;

endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Owns the PPU's single 14-bit VRAM bus and shares it between two requesters. The render fetch engine issues nametable, attribute and pattern fetches. The CPU-side register port issues PPUDATA reads and writes. Each access is a fixed two-phase transaction (address phase, data phase). The block sits between the PPU core's fetch/register logic and the external VRAM/CHR interface, and advances only on `ce` ticks.

## Interface
Parameters:
- `AW`, 14: VRAM address width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `ce` in 1: PPU tick enable. All state and outputs hold when low.
- `render_active` in 1: rendering enabled and the scanline is visible or pre-render. Selects the priority mode.
- `fetch_req` in 1: render fetch request. Level; held until granted.
- `fetch_addr` in AW: fetch address.
- `fetch_gnt` out 1: one-tick pulse; the fetch address has been taken.
- `fetch_valid` out 1: one-tick pulse; `fetch_rdata` is valid.
- `fetch_rdata` out 8: fetched byte.
- `cpu_req` in 1: CPU access request. One-tick pulse, honoured only while `!cpu_busy`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU access address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_busy` out 1: CPU slot occupied.
- `cpu_done` out 1: one-tick pulse; CPU access complete.
- `cpu_rdata` out 8: CPU read data. Valid with `cpu_done` on reads; held afterwards.
- `vram_r` out 1: VRAM read strobe.
- `vram_w` out 1: VRAM write strobe.
- `vram_a` out AW: VRAM address.
- `vram_dout` out 8: VRAM write data.
- `vram_din` in 8: VRAM read data.

## Operation
States: IDLE, FETCH_A, FETCH_D, CPU_A, CPU_D.

CPU slot:
- One entry, holding `we`, `addr` and `wdata`.
- Loaded on a tick where `cpu_req && !cpu_busy`, in any state; `cpu_busy` rises.
- A `cpu_req` while busy is dropped silently.

Decision point: a tick in IDLE, FETCH_D or CPU_D.
- `render_active` = 1: fetch has priority. Go to FETCH_A if `fetch_req`, else CPU_A if the slot is full (or loading this tick), else IDLE.
- `render_active` = 0: CPU has priority. Go to CPU_A if the slot is full, else FETCH_A if `fetch_req`, else IDLE.
- Back-to-back transactions have no IDLE bubble.

Transaction phases:
- Entering FETCH_A: latch `fetch_addr` onto `vram_a`, set `vram_r` = 1, pulse `fetch_gnt`.
- FETCH_A → FETCH_D unconditionally.
- Leaving FETCH_D: capture `vram_din` into `fetch_rdata` and pulse `fetch_valid`.
- CPU_A / CPU_D behave the same way. `vram_a` = slot address; `vram_w` = slot `we`, `vram_r` = !`we`; `vram_dout` = slot `wdata`.
- Leaving CPU_D: for reads capture `vram_din` into `cpu_rdata`; for writes leave `cpu_rdata` unchanged. Pulse `cpu_done`, clear `cpu_busy`.

Bus behaviour:
- Strobes and `vram_a` are stable across both phases and low/held in IDLE.
- `vram_r` and `vram_w` are never high together.
- Memory writes at the end of the data phase.

CPU starvation while `render_active` = 1 is permitted. Hblank and vblank gaps drain the slot.

Reset:
- All outputs 0.
- State IDLE, slot empty.
- An in-flight transaction is abandoned with no `done`/`valid` pulse.

## Timing
- All outputs are registered and change only on ticks with `ce` = 1. Pulses last exactly one ce-tick.
- Fetch latency, with `fetch_req` sampled at tick T:
  - `fetch_gnt` at T+1.
  - `fetch_valid` with data at T+3.
  - Sustained throughput: one fetch per 2 ticks.
- CPU latency, with `cpu_req` at tick T, bus free and no competing fetch:
  - `cpu_busy` from T+1.
  - `vram_r`/`vram_w` at T+1..T+2.
  - `cpu_done` at T+3, with `cpu_busy` low at T+3.
- A new `cpu_req` is accepted in the same tick `cpu_done` is asserted (busy has cleared).
- `render_active` is sampled only at decision points. A change mid-transaction does not abort it.
- `ce` = 0 stretches any phase indefinitely; there is no timeout.

## Structure
- Shared package `ppu_pkg` holds:
  - `vram_arb_state_t` enum: IDLE, FETCH_A, FETCH_D, CPU_A, CPU_D.
  - `PPU_VRAM_AW` = 14.
- Single flat module; no sub-module. The CPU slot is a few registers inline.

## Test plan
- Idle CPU read: `render_active` = 0, `cpu_req`/read of 0x2005, `vram_din` = 0xA7 → `vram_r` high for 2 ticks with `vram_a` = 0x2005, `cpu_done` and `cpu_rdata` = 0xA7 at T+3.
- CPU write: 0x3F00 ← 0x1D → `vram_w` high 2 ticks, `vram_dout` = 0x1D, `vram_r` stays 0, `cpu_rdata` unchanged.
- Continuous fetch: `render_active` = 1, `fetch_req` held for 8 addresses 0x2000..0x2007 → `fetch_gnt` every 2 ticks, 8 `fetch_valid` pulses in order, no bubbles.
- Contention, CPU blocked:
  - `render_active` = 1, continuous fetch, `cpu_req` mid-stream → `cpu_busy` = 1 and no CPU transaction.
  - Drop `fetch_req` → CPU_A entered at the next decision point and completes.
  - Second `cpu_req` while busy → ignored.
- Contention, CPU priority: `render_active` = 0, `cpu_req` and `fetch_req` in the same tick → CPU served first, then fetch.
- Reset and `ce` gating:
  - Assert `reset` during FETCH_A → all outputs 0, no `fetch_valid`.
  - `ce` toggled 1-0-0-1 during a read → phases stretch, data still correct.
